// File: rtl/bus_generator_arbiter_pkg.sv
// Shared definitions for the bus generator arbiter: ID width, broadcast ID and FSM states.
package bus_generator_arbiter_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DELIVER = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_generator_arbiter_bus_rr_channel.sv
// One bus: round-robin arbiter over device input FIFOs, IDLE/GRANT/DELIVER FSM and ID decode.
module bus_rr_channel
    import bus_generator_arbiter_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [drvrs-1:0]                 pop,
    output logic [drvrs-1:0]                 push,
    output logic [drvrs-1:0][pckg_sz-1:0]    D_push
);

    localparam int              IDX_W    = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(drvrs - 1);

    bus_state_e         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic [IDX_W-1:0]   rr_pick_s;
    logic               rr_found_s;
    logic               grant_ok_s;

    // Unicast IDs reach one device (even the source); broadcast reaches all but the source.
    function automatic logic [drvrs-1:0] decode_push(input logic [ID_W-1:0] id,
                                                     input logic [IDX_W-1:0] src);
        logic [drvrs-1:0] mask;
        mask = {drvrs{1'b0}};
        if (int'(id) < drvrs) begin
            for (int i = 0; i < drvrs; i++) begin
                mask[i] = (int'(id) == i);
            end
        end else if (id == broadcast) begin
            for (int i = 0; i < drvrs; i++) begin
                mask[i] = (int'(src) != i);
            end
        end else begin
            mask = {drvrs{1'b0}};
        end
        return mask;
    endfunction

    // Round-robin pick: walk downward so the smallest offset after last_q wins.
    always_comb begin
        rr_found_s = |pndng;
        rr_pick_s  = last_q;
        for (int k = drvrs; k >= 1; k--) begin
            rr_pick_s = pndng[(int'(last_q) + k) % drvrs] ?
                        IDX_W'((int'(last_q) + k) % drvrs) : rr_pick_s;
        end
    end

    // FSM next state; a grant only completes if the chosen FIFO is still non-empty.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        pkt_d      = pkt_q;
        push_d     = {drvrs{1'b0}};
        grant_ok_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_found_s) begin
                    sel_d   = rr_pick_s;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                grant_ok_s = pndng[sel_q];
                if (grant_ok_s) begin
                    pkt_d   = D_pop[sel_q];
                    last_d  = sel_q;
                    push_d  = decode_push(D_pop[sel_q][pckg_sz-1 -: ID_W], sel_q);
                    state_d = ST_DELIVER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELIVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pop strobe for the granted device only.
    always_comb begin
        pop = {drvrs{1'b0}};
        for (int i = 0; i < drvrs; i++) begin
            pop[i] = grant_ok_s && (int'(sel_q) == i);
        end
    end

    // State, pointer and delivery registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_IDX;
            sel_q   <= {IDX_W{1'b0}};
            pkt_q   <= {pckg_sz{1'b0}};
            push_q  <= {drvrs{1'b0}};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            pkt_q   <= pkt_d;
            push_q  <= push_d;
        end
    end

    // The latched packet is presented to every device; push selects who takes it.
    always_comb begin
        for (int i = 0; i < drvrs; i++) begin
            D_push[i] = pkt_q;
        end
        push = push_q;
    end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Top level: an array of independent single-bus round-robin channels.
module bus_generator_arbiter
    import bus_generator_arbiter_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [bits-1:0][drvrs-1:0]                 pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [bits-1:0][drvrs-1:0]                 pop,
    output logic [bits-1:0][drvrs-1:0]                 push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_push
);

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_rr_channel #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_channel (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[b]),
            .D_pop  (D_pop[b]),
            .pop    (pop[b]),
            .push   (push[b]),
            .D_push (D_push[b])
        );
    end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Directed bench for bus_generator_arbiter with one bus of four devices and 16-bit packets.
module tb_bus_generator_arbiter;

    logic                        clk;
    logic                        reset;
    logic [0:0][3:0]             pndng;
    logic [0:0][3:0][15:0]       D_pop;
    logic [0:0][3:0]             pop;
    logic [0:0][3:0]             push;
    logic [0:0][3:0][15:0]       D_push;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [3:0]  g_pop, g_push, d_pop, d_push, a_push;
    logic [63:0] d_data;

    bus_generator_arbiter #(
        .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Drives one packet through GRANT and DELIVER and captures what the DUT did.
    task automatic send_pkt(input int dev, input logic [15:0] data);
        pndng[0][dev] = 1'b1;
        D_pop[0][dev] = data;
        tick();
        g_pop  = pop[0];
        g_push = push[0];
        tick();
        pndng[0][dev] = 1'b0;
        d_pop  = pop[0];
        d_push = push[0];
        d_data = D_push[0];
        tick();
        a_push = push[0];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        pndng[0][0] = 1'b1;
        D_pop[0][0] = 16'h0711;
        tick();
        tick();
        chk_cnt++;
        if (pop[0] !== 4'b0000) $display("FAIL reset_pop got %b want %b", pop[0], 4'b0000);
        else pass_cnt++;
        chk_cnt++;
        if (push[0] !== 4'b0000) $display("FAIL reset_push got %b want %b", push[0], 4'b0000);
        else pass_cnt++;
        chk_cnt++;
        if (D_push[0] !== 64'h0) $display("FAIL reset_dpush got %h want %h", D_push[0], 64'h0);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (pop[0] !== 4'b0000) $display("FAIL release_pop got %b want %b", pop[0], 4'b0000);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pop[0] !== 4'b0001) $display("FAIL first_pop got %b want %b", pop[0], 4'b0001);
        else pass_cnt++;
        tick();
        pndng = '0;
        tick();
    endtask

    task automatic test_unicast();
        apply_reset();
        send_pkt(1, 16'h02AB);
        chk_cnt++;
        if (g_pop !== 4'b0010) $display("FAIL uni_pop got %b want %b", g_pop, 4'b0010);
        else pass_cnt++;
        chk_cnt++;
        if (g_push !== 4'b0000) $display("FAIL uni_push_early got %b want %b", g_push, 4'b0000);
        else pass_cnt++;
        chk_cnt++;
        if (d_pop !== 4'b0000) $display("FAIL uni_pop_len got %b want %b", d_pop, 4'b0000);
        else pass_cnt++;
        chk_cnt++;
        if (d_push !== 4'b0100) $display("FAIL uni_push got %b want %b", d_push, 4'b0100);
        else pass_cnt++;
        chk_cnt++;
        if (d_data !== {4{16'h02AB}}) $display("FAIL uni_data got %h want %h", d_data, {4{16'h02AB}});
        else pass_cnt++;
        chk_cnt++;
        if (a_push !== 4'b0000) $display("FAIL uni_push_len got %b want %b", a_push, 4'b0000);
        else pass_cnt++;
    endtask

    task automatic test_broadcast();
        apply_reset();
        send_pkt(0, 16'hFF5A);
        chk_cnt++;
        if (g_pop !== 4'b0001) $display("FAIL bc_pop got %b want %b", g_pop, 4'b0001);
        else pass_cnt++;
        chk_cnt++;
        if (d_push !== 4'b1110) $display("FAIL bc_push got %b want %b", d_push, 4'b1110);
        else pass_cnt++;
        chk_cnt++;
        if (d_data[63:16] !== {3{16'hFF5A}}) $display("FAIL bc_data got %h want %h", d_data[63:16], {3{16'hFF5A}});
        else pass_cnt++;
    endtask

    task automatic test_drop();
        apply_reset();
        send_pkt(2, 16'h0733);
        chk_cnt++;
        if (g_pop !== 4'b0100) $display("FAIL drop_pop got %b want %b", g_pop, 4'b0100);
        else pass_cnt++;
        chk_cnt++;
        if (d_push !== 4'b0000) $display("FAIL drop_push got %b want %b", d_push, 4'b0000);
        else pass_cnt++;
    endtask

    task automatic test_self();
        apply_reset();
        send_pkt(3, 16'h03CD);
        chk_cnt++;
        if (g_pop !== 4'b1000) $display("FAIL self_pop got %b want %b", g_pop, 4'b1000);
        else pass_cnt++;
        chk_cnt++;
        if (d_push !== 4'b1000) $display("FAIL self_push got %b want %b", d_push, 4'b1000);
        else pass_cnt++;
        chk_cnt++;
        if (d_data[63:48] !== 16'h03CD) $display("FAIL self_data got %h want %h", d_data[63:48], 16'h03CD);
        else pass_cnt++;
    endtask

    // Every device addresses itself, so each grant is followed by a push to the same device.
    task automatic test_round_robin();
        logic [3:0] exp_pop, exp_push;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            D_pop[0][i] = {i[7:0], 8'hA0};
        end
        pndng[0] = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            tick();
            exp_pop  = ((c - 1) % 3 == 0) ? (4'b0001 << (((c - 1) / 3) % 4)) : 4'b0000;
            exp_push = ((c - 1) % 3 == 1) ? (4'b0001 << (((c - 2) / 3) % 4)) : 4'b0000;
            chk_cnt++;
            if (pop[0] !== exp_pop) $display("FAIL rr_pop c%0d got %b want %b", c, pop[0], exp_pop);
            else pass_cnt++;
            chk_cnt++;
            if (push[0] !== exp_push) $display("FAIL rr_push c%0d got %b want %b", c, push[0], exp_push);
            else pass_cnt++;
        end
        pndng = '0;
        tick();
        tick();
    endtask

    task automatic test_abort();
        apply_reset();
        pndng[0][2] = 1'b1;
        D_pop[0][2] = 16'h0101;
        tick();
        pndng[0][2] = 1'b0;
        #1;
        chk_cnt++;
        if (pop[0] !== 4'b0000) $display("FAIL abort_pop got %b want %b", pop[0], 4'b0000);
        else pass_cnt++;
        tick();
        pndng[0] = 4'b1100;
        tick();
        chk_cnt++;
        if (pop[0] !== 4'b0100) $display("FAIL abort_rr got %b want %b", pop[0], 4'b0100);
        else pass_cnt++;
        pndng = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pndng[0][1] = 1'b1;
        D_pop[0][1] = 16'h0211;
        tick();
        tick();
        pndng[0][1] = 1'b0;
        reset = 1'b0;
        #1;
        chk_cnt++;
        if (push[0] !== 4'b0000) $display("FAIL mid_push got %b want %b", push[0], 4'b0000);
        else pass_cnt++;
        tick();
        tick();
        pndng[0] = 4'b0101;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (push[0] !== 4'b0000) $display("FAIL mid_push_rel got %b want %b", push[0], 4'b0000);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (pop[0] !== 4'b0001) $display("FAIL mid_first got %b want %b", pop[0], 4'b0001);
        else pass_cnt++;
        pndng = '0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_drop();
        test_self();
        test_round_robin();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bus_generator_arbiter.md
BUS_GENERATOR_ARBITER -- requirements
Module: bus_generator_arbiter

Interface
REQ-001 Parameter bits, default 1: number of independent buses.
REQ-002 Parameter drvrs, default 4: number of devices (drivers) per bus.
REQ-003 Parameter pckg_sz, default 16: packet width in bits; SHALL be at least 9.
REQ-004 Parameter broadcast, default 8'hFF: ID value meaning "all devices".
REQ-005 One clock; reset is asynchronous and active-low. Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 Port reset, input, 1: asynchronous active-low reset.
REQ-007 Port pndng, input, [bits][drvrs]: device input FIFO not empty.
REQ-008 Port D_pop, input, [bits][drvrs][pckg_sz]: head word of each device input FIFO, valid while pndng is high (first-word-fall-through).
REQ-009 Port pop, output, [bits][drvrs]: one-cycle pop strobe to a device input FIFO.
REQ-010 Port push, output, [bits][drvrs]: one-cycle push strobe to a device output FIFO.
REQ-011 Port D_push, output, [bits][drvrs][pckg_sz]: data written on push.

Function
REQ-012 Each bus SHALL operate independently and identically; no cross-bus interaction.
REQ-013 Packet format: bits [pckg_sz-1:pckg_sz-8] are the destination ID; the remaining low bits are the payload, which is forwarded unchanged.
REQ-014 Each bus SHALL run the FSM IDLE -> GRANT -> DELIVER -> IDLE.
REQ-015 IDLE: if any pndng bit is set, select one device by round-robin and go to GRANT; otherwise stay in IDLE.
REQ-016 Round-robin search SHALL start at the device after the last granted device, wrap from drvrs-1 to 0, and start at device 0 after reset.
REQ-017 GRANT: assert pop for the selected device only, for exactly one cycle; latch that device's D_pop and its index; go to DELIVER.
REQ-018 DELIVER: drive the latched packet on D_push for every device; assert push for one cycle per the ID rules below; return to IDLE.
REQ-019 ID < drvrs: assert push for that device only, including when ID equals the source.
REQ-020 ID == broadcast: assert push for every device except the source.
REQ-021 Any other ID: drop the packet; no push; the pop still occurs.
REQ-022 Latency: pop is asserted one cycle after pndng is sampled in IDLE; push follows in the next cycle. Peak throughput is one packet per 3 cycles per bus.
REQ-023 If pndng of the selected device falls between IDLE and GRANT, abort to IDLE without pop; the round-robin pointer does not advance.
REQ-024 At most one pop bit per bus SHALL be high in any cycle.
REQ-025 pop and push SHALL never be high in the same cycle on the same bus.
REQ-026 Output back-pressure is not modelled; push is never stalled.

Reset
REQ-027 While reset is low: pop=0, push=0, D_push=0, FSM=IDLE, round-robin pointer=drvrs-1 (so device 0 is searched first).
REQ-028 Reset asserted mid-transfer discards the latched packet; no push is issued after release.
REQ-029 First possible pop is on the second rising edge after reset deasserts.

Structure
REQ-030 A shared package SHALL hold ID_W=8, the default broadcast value 8'hFF, and the FSM state enum.
REQ-031 One sub-module, bus_rr_channel, SHALL implement a single bus: arbiter, FSM and ID decode. The top SHALL instantiate it bits times.
REQ-032 Target size: 120-400 RTL lines in total.

Verification
REQ-033 Device 1 pndng with D_pop=16'h02AB -> pop[0][1] for 1 cycle; next cycle push[0][2]=1 with D_push=16'h02AB; no other push.
REQ-034 D_pop=16'hFF5A from device 0 -> push[0] on devices 1, 2 and 3 only, all with data 16'hFF5A.
REQ-035 All four pndng bits held high after reset -> grants in the order 0, 1, 2, 3, 0, each pop 3 cycles apart.
REQ-036 ID 8'h07 with drvrs=4 -> pop occurs; no push.
REQ-037 Reset driven low during DELIVER -> push stays 0; after release device 0 is served first.
REQ-038 ID equal to the source (device 3 sends 16'h03CD) -> push[0][3]=1 with D_push=16'h03CD.
